// File: rtl/hex_scan_mux.sv
// Multiplexed 8-digit hex display scanner: steps through the digits of a
// shadowed 32-bit word, with optional leading-zero blanking and display freeze.
module hex_scan_mux #(
    parameter int REFRESH_DIV = 50000,
    parameter int NUM_DIGITS  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] value,
    input  logic        freeze,
    input  logic        blank_lz,
    output logic [3:0]  bin,
    output logic [7:0]  digit_en,
    output logic [2:0]  digit_idx,
    output logic        frame_tick
);

    localparam logic [15:0] DIV_LAST = 16'(REFRESH_DIV - 1);

    logic [15:0] div_cnt_q, div_cnt_d;
    logic [2:0]  digit_idx_q, digit_idx_d;
    logic [31:0] shadow_q, shadow_d;
    logic        frame_tick_q, frame_tick_d;
    logic        tc;
    logic        frame_end;
    logic [2:0]  msd;
    logic        blanked;

    always_comb begin
        tc           = (div_cnt_q == DIV_LAST);
        frame_end    = tc && (digit_idx_q == 3'd7);
        div_cnt_d    = tc ? 16'd0 : div_cnt_q + 16'd1;
        digit_idx_d  = tc ? digit_idx_q + 3'd1 : digit_idx_q;
        // The shadow only changes at a frame boundary, so a frame never tears.
        shadow_d     = (frame_end && !freeze) ? value : shadow_q;
        frame_tick_d = frame_end;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt_q    <= 16'd0;
            digit_idx_q  <= 3'd0;
            shadow_q     <= 32'h0;
            frame_tick_q <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            digit_idx_q  <= digit_idx_d;
            shadow_q     <= shadow_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    // Highest nonzero nibble wins; an all-zero word leaves msd at 0.
    always_comb begin
        msd = 3'd0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (shadow_q[4*k +: 4] != 4'h0) begin
                msd = 3'(k);
            end
        end
    end

    always_comb begin
        blanked    = blank_lz && (digit_idx_q > msd);
        bin        = shadow_q[{digit_idx_q, 2'b00} +: 4];
        digit_en   = blanked ? 8'hFF : ~(8'h01 << digit_idx_q);
        digit_idx  = digit_idx_q;
        frame_tick = frame_tick_q;
    end

endmodule

// File: tb/tb_hex_scan_mux.sv
// Bench for hex_scan_mux: four instances (REFRESH_DIV 1,3,4,5) checked every
// cycle against a frame-count model, plus a vector table and corner sequences.
module tb_hex_scan_mux;

    function automatic int div_of(input int k);
        case (k)
            0:       return 1;
            1:       return 3;
            2:       return 4;
            default: return 5;
        endcase
    endfunction

    logic        clk;
    logic        rst;
    logic [31:0] value;
    logic        freeze;
    logic        blank_lz;
    logic [3:0]  bin_o        [4];
    logic [7:0]  digit_en_o   [4];
    logic [2:0]  digit_idx_o  [4];
    logic        frame_tick_o [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        hex_scan_mux #(
            .REFRESH_DIV (div_of(gi)),
            .NUM_DIGITS  (8)
        ) u_dut (
            .clk        (clk),
            .rst        (rst),
            .value      (value),
            .freeze     (freeze),
            .blank_lz   (blank_lz),
            .bin        (bin_o[gi]),
            .digit_en   (digit_en_o[gi]),
            .digit_idx  (digit_idx_o[gi]),
            .frame_tick (frame_tick_o[gi])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Model: edges since release, and the word captured at the last unfrozen boundary.
    int          m_n [4];
    logic [31:0] m_s [4];

    typedef struct {
        logic [31:0] value;
        logic        blank;
        int          idx;
        logic [3:0]  bin;
        logic [7:0]  en;
    } vec_t;
    vec_t vecs [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic bound_fail(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s: wait bound expired", nm);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_n[k] = 0;
            m_s[k] = 32'h0;
        end
    endtask

    // One clock: advance the model at the rising edge, compare all instances at the falling edge.
    task automatic tick();
        int d, ei, msd;
        logic [3:0]  eb;
        logic [7:0]  een;
        logic        et;
        @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            if (!rst) begin
                m_n[k] = 0;
                m_s[k] = 32'h0;
            end else begin
                m_n[k]++;
                if ((m_n[k] % (8 * div_of(k))) == 0 && !freeze) m_s[k] = value;
            end
        end
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            d   = div_of(k);
            ei  = (m_n[k] / d) % 8;
            eb  = m_s[k][4*ei +: 4];
            msd = 0;
            for (int j = 0; j < 8; j++) if (m_s[k][4*j +: 4] != 4'h0) msd = j;
            een = (blank_lz && ei > msd) ? 8'hFF : ~(8'h01 << ei);
            et  = rst && m_n[k] > 0 && (m_n[k] % (8 * d)) == 0;
            n_tests++;
            if ({bin_o[k], digit_en_o[k], digit_idx_o[k], frame_tick_o[k]} !== {eb, een, 3'(ei), et}) begin
                n_fail++;
                $display("FAIL scoreboard div=%0d n=%0d: got bin=%h en=%h idx=%0d tick=%b expected bin=%h en=%h idx=%0d tick=%b",
                         d, m_n[k], bin_o[k], digit_en_o[k], digit_idx_o[k], frame_tick_o[k], eb, een, ei, et);
            end
        end
    endtask

    task automatic wait_frame(input int k, input int limit, input string nm);
        int c = 0;
        do begin
            tick();
            c++;
        end while (!frame_tick_o[k] && c < limit);
        if (!frame_tick_o[k]) bound_fail(nm);
    endtask

    task automatic wait_idx(input int k, input logic [2:0] target, input int limit, input string nm);
        int c = 0;
        while (digit_idx_o[k] != target && c < limit) begin
            tick();
            c++;
        end
        if (digit_idx_o[k] != target) bound_fail(nm);
    endtask

    initial begin
        logic [31:0] word;
        logic [7:0]  en_seq [8];
        int          cnt;

        vecs[0]  = '{32'h1234ABCD, 1'b0, 0, 4'hD, 8'hFE};
        vecs[1]  = '{32'h1234ABCD, 1'b0, 7, 4'h1, 8'h7F};
        vecs[2]  = '{32'h1234ABCD, 1'b1, 7, 4'h1, 8'h7F};
        vecs[3]  = '{32'h000000A5, 1'b1, 1, 4'hA, 8'hFD};
        vecs[4]  = '{32'h000000A5, 1'b1, 2, 4'h0, 8'hFF};
        vecs[5]  = '{32'h000000A5, 1'b1, 7, 4'h0, 8'hFF};
        vecs[6]  = '{32'h000000A5, 1'b0, 2, 4'h0, 8'hFB};
        vecs[7]  = '{32'h00000000, 1'b1, 0, 4'h0, 8'hFE};
        vecs[8]  = '{32'h00000000, 1'b1, 5, 4'h0, 8'hFF};
        vecs[9]  = '{32'h00F00000, 1'b1, 5, 4'hF, 8'hDF};
        vecs[10] = '{32'h00F00000, 1'b1, 4, 4'h0, 8'hEF};
        vecs[11] = '{32'h00F00000, 1'b1, 6, 4'h0, 8'hFF};
        en_seq = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

        rst      = 1'b0;
        value    = 32'h1234ABCD;
        freeze   = 1'b0;
        blank_lz = 1'b0;
        model_reset();

        // Reset state
        repeat (3) tick();
        for (int k = 0; k < 4; k++) begin
            chk("reset_bin", 32'(bin_o[k]), 32'h0);
            chk("reset_en", 32'(digit_en_o[k]), 32'hFE);
        end
        rst = 1'b1;

        // Basic scan at div 4: after first boundary, nibbles D,C,B,A,4,3,2,1, 4 cycles each
        wait_frame(2, 40, "first_frame_div4");
        word = 32'h1234ABCD;
        for (int c = 0; c < 32; c++) begin
            chk("scan_bin_div4", 32'(bin_o[2]), 32'(word[4*(c/4) +: 4]));
            chk("scan_en_div4", 32'(digit_en_o[2]), 32'(en_seq[c/4]));
            tick();
        end

        // Table vectors on the div-1 instance
        for (int v = 0; v < 12; v++) begin
            value    = vecs[v].value;
            blank_lz = vecs[v].blank;
            wait_frame(0, 20, "table_frame");
            wait_idx(0, 3'(vecs[v].idx), 16, "table_idx");
            chk($sformatf("table%0d_bin", v), 32'(bin_o[0]), 32'(vecs[v].bin));
            chk($sformatf("table%0d_en", v), 32'(digit_en_o[0]), 32'(vecs[v].en));
        end
        blank_lz = 1'b0;

        // Tear-free: value changes while div-3 instance shows digit 3
        value = 32'h11111111;
        wait_frame(1, 30, "tear_load");
        wait_idx(1, 3'd3, 30, "tear_idx3");
        value = 32'h22222222;
        cnt = 0;
        do begin
            chk("tear_old_word", 32'(bin_o[1]), 32'h1);
            tick();
            cnt++;
        end while (!frame_tick_o[1] && cnt < 40);
        chk("tear_new_word", 32'(bin_o[1]), 32'h2);
        chk("tear_new_idx", 32'(digit_idx_o[1]), 32'h0);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!frame_tick_o[1] && cnt < 40);
        chk("tick_period_div3", 32'(cnt), 32'd24);

        // Freeze across 3 frames at div 4
        wait_frame(2, 40, "freeze_align");
        freeze = 1'b1;
        value  = 32'hCAFEF00D;
        cnt = 0;
        for (int c = 0; c < 96; c++) begin
            tick();
            if (frame_tick_o[2]) cnt++;
            if (c % 8 == 0) chk("frozen_bin", 32'(bin_o[2]), 32'h2);
        end
        chk("frozen_tick_count", 32'(cnt), 32'd3);
        freeze = 1'b0;
        wait_frame(2, 40, "unfreeze_frame");
        chk("unfrozen_bin", 32'(bin_o[2]), 32'hD);

        // div 1: frame_tick every 8th cycle
        cnt = 0;
        for (int c = 0; c < 64; c++) begin
            tick();
            if (frame_tick_o[0]) cnt++;
        end
        chk("div1_tick_count", 32'(cnt), 32'd8);

        // Randomized traffic, checked by the scoreboard
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0) value = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 39) == 0) freeze = ~freeze;
            if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
            tick();
        end
        freeze = 1'b0;

        // Asynchronous reset mid-cycle while div-5 instance shows digit 6
        wait_idx(3, 3'd6, 50, "reset_idx6");
        #2 rst = 1'b0;
        #1;
        model_reset();
        chk("async_reset_bin", 32'(bin_o[3]), 32'h0);
        chk("async_reset_en", 32'(digit_en_o[3]), 32'hFE);
        chk("async_reset_idx", 32'(digit_idx_o[3]), 32'h0);
        repeat (2) tick();
        rst = 1'b1;
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (digit_idx_o[3] != 3'd1 && cnt < 20);
        chk("release_to_idx1_edges", 32'(cnt), 32'd5);
        repeat (50) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/hex_scan_mux.md
HEX_SCAN_MUX -- requirements
Module: hex_scan_mux

Interface
REQ-001 Parameter REFRESH_DIV, default 50000: clock cycles each digit is displayed; legal range 1..65535.
REQ-002 Parameter NUM_DIGITS, default 8: number of hex digits scanned; fixed at 8 in this revision.
REQ-003 Port clk  input  1: single system clock; all state changes on its rising edge.
REQ-004 Port rst  input  1: asynchronous, active-low reset; asserting it (0) immediately forces reset state; state changes resume on the first rising clk edge after it goes to 1.
REQ-005 Port value  input  32: word to display, e.g. PC or register contents; digit k is value[4k+3:4k].
REQ-006 Port freeze  input  1: when 1, the displayed word is not refreshed at frame boundaries.
REQ-007 Port blank_lz  input  1: when 1, enables leading-zero blanking.
REQ-008 Port bin  output  4: nibble of the active digit, fed to the binary-to-7-segment decoder.
REQ-009 Port digit_en  output  8: active-low digit (anode) enables; bit k low selects digit k.
REQ-010 Port digit_idx  output  3: index of the active digit.
REQ-011 Port frame_tick  output  1: one-cycle pulse marking a frame boundary.

Function
REQ-012 The block SHALL hold a 16-bit divider counter div_cnt that counts 0..REFRESH_DIV-1 and wraps to 0.
- Terminal count (tc): div_cnt == REFRESH_DIV-1.
REQ-013 On every clk edge with tc true, digit_idx SHALL advance by 1, wrapping 7 -> 0.
- It SHALL hold otherwise.
REQ-014 With REFRESH_DIV = 1, tc SHALL be permanently true, so digit_idx advances every cycle.
REQ-015 The block SHALL hold a 32-bit shadow register.
- bin and digit_en are derived only from the shadow register, never directly from value.
REQ-016 Frame boundary: the clk edge on which tc is true and digit_idx == 7.
- At that edge, if freeze == 0, shadow SHALL load value (sampled at that edge).
- If freeze == 1, shadow SHALL hold.
REQ-017 frame_tick SHALL be registered and high for exactly the one cycle following each frame boundary edge, independent of freeze.
REQ-018 bin SHALL equal shadow[4*digit_idx+3 : 4*digit_idx], combinationally from registered state (zero latency relative to digit_idx).
REQ-019 Significant digit count: msd = index of the highest nonzero nibble of shadow, or 0 if shadow == 0.
REQ-020 digit_en SHALL be all ones except bit digit_idx, which is 0, unless that digit is blanked.
REQ-021 A digit SHALL be blanked (digit_en = 8'hFF) only when blank_lz == 1 and digit_idx > msd.
- Digit 0 is never blanked, so a zero word shows a single "0".
REQ-022 blank_lz SHALL take effect combinationally; changing it mid-frame affects only the currently displayed digit onward.
REQ-023 Changes on value between frame boundaries SHALL have no effect on any output (tear-free display).
REQ-024 Exactly one or zero bits of digit_en SHALL be low in every cycle.

Reset
REQ-025 While rst == 0 the block SHALL hold:
- div_cnt = 0, digit_idx = 0, shadow = 32'h0, frame_tick = 0
- hence bin = 4'h0 and digit_en = 8'hFE
REQ-026 Reset asserted mid-frame SHALL abort the scan.
- After release, scanning restarts at digit 0 with a full REFRESH_DIV dwell.
- The first frame boundary occurs 8*REFRESH_DIV edges after release.
REQ-027 Because shadow resets to 0, the display SHALL show 0 until the first frame boundary loads value.

Verification
REQ-028 REFRESH_DIV=4, value=32'h1234ABCD, freeze=0, blank_lz=0, reset released.
- After the first frame boundary, successive digit_idx 0..7 show bin D,C,B,A,4,3,2,1.
- digit_en steps FE,FD,FB,F7,EF,DF,BF,7F.
- Each step lasts 4 cycles.
REQ-029 REFRESH_DIV=2, value=32'h0000_00A5, blank_lz=1.
- digit_en is low at indices 0 and 1 (bin 5, A).
- digit_en = FF for indices 2..7.
- With value=0: only index 0 is enabled, with bin 0.
REQ-030 REFRESH_DIV=3: change value from 32'h11111111 to 32'h22222222 while digit_idx=3.
- bin stays 1 for the remainder of that frame and becomes 2 starting at digit 0 of the next frame.
- frame_tick pulses once per 24 cycles.
REQ-031 freeze=1 asserted before a frame boundary, value changed.
- Outputs keep the old word across 3 frames, while frame_tick still pulses.
- The new word appears at the first boundary after freeze=0.
REQ-032 REFRESH_DIV=5: assert rst asynchronously (mid-cycle) while digit_idx=6.
- Outputs go immediately to bin=0, digit_en=FE.
- After release, digit_idx=1 first occurs 5 edges later.
REQ-033 REFRESH_DIV=1: digit_idx increments every cycle.
- frame_tick is high every 8th cycle.
